// File: rtl/rpn_pkg.sv
// Shared types and constants for the RPN stack calculator: op set, key codes, mode banks.
package rpn_pkg;

    typedef enum logic [3:0] {
        OP_PUSH, OP_POP, OP_SWAP, OP_CLEAR,
        OP_ADD,  OP_SUB, OP_MUL,  OP_NEG,
        OP_AND,  OP_OR,  OP_XOR,  OP_NOT,
        OP_SHL,  OP_SHR, OP_DUP,  OP_LT
    } op_t;

    localparam logic [3:0] KEY0     = 4'b1110;
    localparam logic [3:0] KEY1     = 4'b1101;
    localparam logic [3:0] KEY2     = 4'b1011;
    localparam logic [3:0] KEY3     = 4'b0111;
    localparam logic [3:0] KEY_IDLE = 4'b1111;

    localparam logic [1:0] MODE_STACK = 2'd0;
    localparam logic [1:0] MODE_ARITH = 2'd1;
    localparam logic [1:0] MODE_LOGIC = 2'd2;
    localparam logic [1:0] MODE_SHIFT = 2'd3;

    // The op enum is laid out as {mode, key index}, so decode is a concatenation.
    function automatic op_t decode_op(input logic [1:0] mode, input logic [3:0] press);
        logic [1:0] kidx;
        case (press)
            4'b0010: kidx = 2'd1;
            4'b0100: kidx = 2'd2;
            4'b1000: kidx = 2'd3;
            default: kidx = 2'd0;
        endcase
        return op_t'({mode, kidx});
    endfunction

endpackage

// File: rtl/rpn_stack_calc_key_press_detect.sv
// Active-low key synchroniser and one-hot press detector; strobe is valid the cycle after
// the second sync flop sees the press, and only after the keys have been seen idle once.
module key_press_detect
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key_i,
    output logic [3:0] press_o
);
    import rpn_pkg::*;

    logic [3:0] sync1_q, sync2_q, prev_q;
    logic [1:0] warm_q;
    logic       armed_q;
    logic       one_low;

    // armed_q blocks a key held through reset until a real idle sample has been seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= KEY_IDLE;
            sync2_q <= KEY_IDLE;
            prev_q  <= KEY_IDLE;
            warm_q  <= 2'b00;
            armed_q <= 1'b0;
        end else begin
            sync1_q <= key_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            warm_q  <= {warm_q[0], 1'b1};
            armed_q <= armed_q | (warm_q[1] && (sync2_q == KEY_IDLE));
        end
    end

    assign one_low = (sync2_q == KEY0) || (sync2_q == KEY1) ||
                     (sync2_q == KEY2) || (sync2_q == KEY3);
    assign press_o = (armed_q && one_low && (prev_q == KEY_IDLE)) ? ~sync2_q : 4'b0000;

endmodule

// File: rtl/rpn_stack_calc.sv
// Push-button RPN stack calculator: register-array stack, ops commit two edges after the
// synchronised key edge; rejected ops leave the stack untouched and raise err.
module rpn_stack_calc #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int CW    = 8
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode_i,
    input  logic [3:0]       key_i,
    input  logic [WIDTH-1:0] val_i,
    output logic [WIDTH-1:0] top_o,
    output logic [WIDTH-1:0] next_o,
    output logic [CW-1:0]    counter_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             err_o
);
    import rpn_pkg::*;

    localparam int            AW      = $clog2(DEPTH);
    localparam int            SW      = $clog2(WIDTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [3:0]       press;
    op_t              op;
    logic [WIDTH-1:0] stk_q [DEPTH];
    logic [CW-1:0]    depth_q, depth_d, nd;
    logic             err_q, err_d;
    logic             has1, has2, room, ok;
    logic [AW-1:0]    i_top, i_nxt, i_new;
    logic [WIDTH-1:0] a, b, alu;
    logic             want_a, want_b, wa_en, wb_en;
    logic [AW-1:0]    wa_idx, wb_idx;
    logic [WIDTH-1:0] wa_dat, wb_dat;

    key_press_detect u_kpd (
        .clk     (clk),
        .rst_n   (rst_n),
        .key_i   (key_i),
        .press_o (press)
    );

    assign has1  = (depth_q != '0);
    assign has2  = (depth_q > CW'(1));
    assign room  = (depth_q != DEPTH_C);
    assign i_top = AW'(depth_q - CW'(1));
    assign i_nxt = AW'(depth_q - CW'(2));
    assign i_new = AW'(depth_q);
    // Gating by depth keeps stale entries below the pointer invisible.
    assign a     = has1 ? stk_q[i_top] : '0;
    assign b     = has2 ? stk_q[i_nxt] : '0;
    assign op    = decode_op(mode_i, press);

    always_comb begin
        alu = a;
        case (op)
            OP_ADD:  alu = b + a;
            OP_SUB:  alu = b - a;
            OP_MUL:  alu = b * a;
            OP_NEG:  alu = -a;
            OP_AND:  alu = b & a;
            OP_OR:   alu = b | a;
            OP_XOR:  alu = b ^ a;
            OP_NOT:  alu = ~a;
            OP_SHL:  alu = b << a[SW-1:0];
            OP_SHR:  alu = b >> a[SW-1:0];
            OP_LT:   alu = {{(WIDTH-1){1'b0}}, (b < a)};
            default: alu = a;
        endcase
    end

    always_comb begin
        nd     = depth_q;
        ok     = 1'b0;
        want_a = 1'b0;
        want_b = 1'b0;
        wa_idx = i_top;
        wa_dat = alu;
        wb_idx = i_nxt;
        wb_dat = a;
        case (op)
            OP_PUSH: begin
                ok = room;  want_a = 1'b1; wa_idx = i_new; wa_dat = val_i;
                nd = depth_q + CW'(1);
            end
            OP_DUP: begin
                ok = room && has1; want_a = 1'b1; wa_idx = i_new; wa_dat = a;
                nd = depth_q + CW'(1);
            end
            OP_POP: begin
                ok = has1; nd = depth_q - CW'(1);
            end
            OP_CLEAR: begin
                ok = 1'b1; nd = '0;
            end
            OP_SWAP: begin
                ok = has2; want_a = 1'b1; wa_dat = b; want_b = 1'b1;
            end
            OP_NEG, OP_NOT: begin
                ok = has1; want_a = 1'b1;
            end
            default: begin
                ok = has2; want_a = 1'b1; wa_idx = i_nxt; nd = depth_q - CW'(1);
            end
        endcase

        depth_d = depth_q;
        err_d   = err_q;
        wa_en   = 1'b0;
        wb_en   = 1'b0;
        if (|press) begin
            err_d = !ok;
            if (ok) begin
                depth_d = nd;
                wa_en   = want_a;
                wb_en   = want_b;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            depth_q <= '0;
            err_q   <= 1'b0;
        end else begin
            depth_q <= depth_d;
            err_q   <= err_d;
        end
    end

    // Storage carries no reset: contents above the pointer are never observable.
    always_ff @(posedge clk) begin
        if (wa_en) stk_q[wa_idx] <= wa_dat;
        if (wb_en) stk_q[wb_idx] <= wb_dat;
    end

    assign top_o     = a;
    assign next_o    = b;
    assign counter_o = depth_q;
    assign full_o    = (depth_q == DEPTH_C);
    assign empty_o   = (depth_q == '0);
    assign err_o     = err_q;

endmodule

// File: doc/rpn_stack_calc.md
RPN_STACK_CALC -- requirements
Module: rpn_stack_calc

Interface
REQ-001 Parameter WIDTH, default 16: data width of val, top and next.
REQ-002 Parameter DEPTH, default 8: stack capacity in entries; legal range 2..255.
REQ-003 Parameter CW, default 8: counter width; CW SHALL hold DEPTH.
REQ-004 clk  in  1  single clock; all state updates on posedge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 mode  in  2  operation bank select; quasi-static switch input.
REQ-007 key  in  4  push-buttons, active-low; a pressed key reads 0.
REQ-008 val  in  WIDTH  operand for push; quasi-static switch input.
REQ-009 top  out  WIDTH  stack entry 0; 0 when empty.
REQ-010 next  out  WIDTH  stack entry 1; 0 when depth<2.
REQ-011 counter  out  CW  current stack depth.
REQ-012 full  out  1  high when depth==DEPTH.
REQ-013 empty  out  1  high when depth==0.
REQ-014 err  out  1  high when the most recent press was rejected.

Function
REQ-015 key SHALL pass through a 2-flop synchroniser; a press is a 1->0 transition of exactly one synchronised bit while the other three synchronised bits are 1.
REQ-016 A press in which zero or more than one bit is low SHALL be ignored: no state change and err unchanged.
REQ-017 Each press SHALL execute exactly one operation, regardless of hold duration; a new press requires release to 1111 first.
REQ-018 key low before edge E0 SHALL commit the operation at edge E2; outputs SHALL reflect the result after E2.
REQ-019 mode and val SHALL be sampled at the commit edge.
REQ-020 mode 0 ops: key0 push val; key1 pop; key2 swap top/next; key3 clear (depth=0).
REQ-021 mode 1 ops: key0 add; key1 subtract (next-top); key2 multiply, low WIDTH bits; key3 negate top (two's complement).
REQ-022 mode 2 ops: key0 AND; key1 OR; key2 XOR; key3 bitwise NOT of top.
REQ-023 mode 3 ops: key0 shift next left by top[log2(WIDTH)-1:0]; key1 logical shift right, same amount; key2 duplicate top; key3 unsigned less-than (next<top ? 1 : 0).
REQ-024 Binary ops SHALL pop two entries and push one result, so depth decreases by 1.
REQ-025 Unary ops SHALL replace top in place.
REQ-026 All arithmetic SHALL be modulo 2^WIDTH; no carry or overflow output.
REQ-027 Rejected operations SHALL leave the stack unchanged and set err:
- push or dup when full;
- pop, unary ops or dup when empty;
- binary ops or swap when depth<2.
REQ-028 Any accepted operation SHALL clear err; clear is always accepted.
REQ-029 Entries below depth SHALL be unobservable; a pop followed by a push SHALL show only the new value.

Reset
REQ-030 rst low SHALL asynchronously set:
- depth=0, top=0, next=0, counter=0;
- full=0, empty=1, err=0;
- synchroniser and edge-detect registers to 1111.
REQ-031 A press in flight at reset SHALL be discarded.
REQ-032 After rst rises, a key already held low SHALL NOT execute until it is released and pressed again.

Structure
REQ-033 Shared package rpn_pkg SHALL hold:
- the op enum typedef (16 ops);
- the key one-hot constants KEY0..KEY3 = 1110, 1101, 1011, 0111;
- the mode constants.
REQ-034 Sub-module key_press_detect (synchroniser plus one-hot edge detect, 4-bit pressed-strobe output) SHALL be instantiated once.
REQ-035 Storage SHALL be a DEPTH x WIDTH register array with a depth pointer; top and next SHALL be driven combinationally from the array and pointer.

Verification
REQ-036 Reset: rst=0 with key=1110 held; release rst while still holding -> depth 0, empty=1; no push until release and re-press.
REQ-037 Arithmetic: push 0x0007, push 0x0003, mode1 key1 -> top=0x0004, next=0, counter=1; push 0xFFFF, mode1 key0 -> top=0x0003.
REQ-038 Full: DEPTH=8, push 1..8 -> full=1, counter=8, top=0x0008; ninth push of 0x0009 -> err=1, top=0x0008, counter=8.
REQ-039 Empty: after clear, mode1 key0 -> err=1, counter=0, top=0; then push 0x0005 -> err=0, top=0x0005.
REQ-040 Key handling:
- hold key0 low for 20 cycles -> exactly one push;
- key=1100 -> ignored;
- key=1110 -> 1100 -> 1110 -> no extra op.
REQ-041 Parametrisation: WIDTH=8, DEPTH=2 build: push 0xF0, push 0x04, mode3 key0 -> top=0x00, counter=1.
